// File: rtl/string_sender.sv
// Streams a ROM string, first character first, one byte per handshake to the UART TX.
// Define STRING_SENDER_CRLF_EN to append CR LF after every string.
module string_sender #(
  parameter int ID_W      = 2,
  parameter int STR_BYTES = 32,
  parameter int LEN_W     = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [ID_W-1:0]        id,
  output logic                   busy,
  output logic                   done,
  output logic [ID_W-1:0]        rom_id,
  input  logic [STR_BYTES*8-1:0] rom_string,
  input  logic [LEN_W-1:0]       rom_length,
  output logic [7:0]             tx_data,
  output logic                   tx_valid,
  input  logic                   tx_ready
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] LOAD = 3'd1;
  localparam logic [2:0] SEND = 3'd2;
  localparam logic [2:0] DONE = 3'd3;
  localparam logic [2:0] CR   = 3'd4;
  localparam logic [2:0] LF   = 3'd5;

`ifdef STRING_SENDER_CRLF_EN
  localparam bit CRLF = 1'b1;
`else
  localparam bit CRLF = 1'b0;
`endif

  logic [2:0]             state;
  logic [STR_BYTES*8-1:0] str_r;
  logic [LEN_W-1:0]       len_r;
  logic [LEN_W-1:0]       idx;

  // The string is right-justified: character i sits len-1-i bytes above bit 0.
  function automatic logic [7:0] char_at(input logic [STR_BYTES*8-1:0] s,
                                         input logic [LEN_W-1:0] len,
                                         input logic [LEN_W-1:0] i);
    logic [LEN_W-1:0]       pos;
    logic [STR_BYTES*8-1:0] sh;
    pos = len - i - LEN_W'(1);
    sh  = s >> {pos, 3'b000};
    return sh[7:0];
  endfunction

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      rom_id   <= '0;
      tx_data  <= '0;
      tx_valid <= 1'b0;
      str_r    <= '0;
      len_r    <= '0;
      idx      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            rom_id <= id;
            state  <= LOAD;
          end
        end
        LOAD: begin
          str_r <= rom_string;
          len_r <= rom_length;
          idx   <= '0;
          if (rom_length != '0) begin
            tx_data  <= char_at(rom_string, rom_length, {LEN_W{1'b0}});
            tx_valid <= 1'b1;
            state    <= SEND;
          end else if (CRLF) begin
            tx_data  <= 8'h0D;
            tx_valid <= 1'b1;
            state    <= CR;
          end else begin
            state <= DONE;
          end
        end
        SEND: begin
          // tx_valid is always high here, so tx_ready alone marks a handshake.
          if (tx_ready) begin
            if (idx == len_r - LEN_W'(1)) begin
              if (CRLF) begin
                tx_data <= 8'h0D;
                state   <= CR;
              end else begin
                tx_valid <= 1'b0;
                state    <= DONE;
              end
            end else begin
              idx     <= idx + LEN_W'(1);
              tx_data <= char_at(str_r, len_r, idx + LEN_W'(1));
            end
          end
        end
        CR: begin
          if (tx_ready) begin
            tx_data <= 8'h0A;
            state   <= LF;
          end
        end
        LF: begin
          if (tx_ready) begin
            tx_valid <= 1'b0;
            state    <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_string_sender.sv
// Directed self-checking bench for string_sender with a combinational ROM stub.
// Compile with +define+STRING_SENDER_CRLF_EN to exercise the CR LF build.
module tb_string_sender;

  localparam int ID_W      = 2;
  localparam int STR_BYTES = 32;
  localparam int LEN_W     = 5;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   start = 1'b0;
  logic [ID_W-1:0]        id = '0;
  logic                   busy, done;
  logic [ID_W-1:0]        rom_id;
  logic [STR_BYTES*8-1:0] rom_string;
  logic [LEN_W-1:0]       rom_length;
  logic [7:0]             tx_data;
  logic                   tx_valid;
  logic                   tx_ready = 1'b1;
  logic                   zero_len = 1'b0;

  int checks = 0;
  int errors = 0;
  logic [7:0] got[$];
  logic [7:0] exp[$];
  int ndone;

  string_sender #(.ID_W(ID_W), .STR_BYTES(STR_BYTES), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .start(start), .id(id), .busy(busy), .done(done),
    .rom_id(rom_id), .rom_string(rom_string), .rom_length(rom_length),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
  );

  always #5 clk = ~clk;

  // ROM stub
  always_comb begin
    rom_string = '0;
    rom_length = '0;
    case (rom_id)
      2'd0: begin rom_string = 256'("error: invalid command"); rom_length = 5'd22; end
      2'd1: begin rom_string = 256'("\n$>");                    rom_length = 5'd3;  end
      2'd2: begin rom_string = 256'("OK");                      rom_length = 5'd2;  end
      default: begin rom_string = 256'("PONG");                rom_length = 5'd4;  end
    endcase
    if (zero_len) rom_length = '0;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Builds the expected byte stream, adding CR LF when that build option is on.
  task automatic expect_str(input string s);
    exp.delete();
    for (int i = 0; i < s.len(); i++) exp.push_back(s[i]);
`ifdef STRING_SENDER_CRLF_EN
    exp.push_back(8'h0D);
    exp.push_back(8'h0A);
`endif
  endtask

  // Issues a start, then runs a fixed window recording handshaken bytes and done pulses.
  // mode 0: tx_ready always high; mode 1: tx_ready pattern 1,0,0 repeating.
  // start_at >= 0 re-pulses start (id=2) in that window cycle (0 = cycle after the start).
  task automatic run(input logic [ID_W-1:0] sid, input int mode, input int start_at);
    logic       prev_stall;
    logic [7:0] prev_data;
    got.delete();
    ndone      = 0;
    prev_stall = 1'b0;
    prev_data  = '0;
    id    = sid;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 40; c++) begin
      tx_ready = (mode == 0) ? 1'b1 : ((c % 3) == 0);
      start    = (c == start_at);
      if (c == start_at) id = 2'd2;
      if (prev_stall) begin
        chk("hold_valid", {31'd0, tx_valid}, 32'd1);
        chk("hold_data", {24'd0, tx_data}, {24'd0, prev_data});
      end
      if (tx_valid && tx_ready) got.push_back(tx_data);
      if (done) ndone++;
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;
      tick();
    end
    start    = 1'b0;
    tx_ready = 1'b1;
  endtask

  task automatic cmp_bytes(input string tag);
    chk({tag, "_count"}, got.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got.size(); i++)
      chk($sformatf("%s_byte%0d", tag, i), {24'd0, got[i]}, {24'd0, exp[i]});
    chk({tag, "_done"}, ndone, 1);
  endtask

  initial begin
    // Reset state
    rst = 1'b1;
    tick(); tick();
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_valid", {31'd0, tx_valid}, 0);
    chk("rst_data", {24'd0, tx_data}, 0);
    chk("rst_romid", {30'd0, rom_id}, 0);
    rst = 1'b0;
    tick();

`ifndef STRING_SENDER_CRLF_EN
    // PONG with exact cycle timing; this is cycle N
    id = 2'd3; start = 1'b1;
    tick(); start = 1'b0;
    chk("pong_n1_busy", {31'd0, busy}, 1);
    chk("pong_n1_romid", {30'd0, rom_id}, 3);
    chk("pong_n1_valid", {31'd0, tx_valid}, 0);
    tick(); chk("pong_n2", {23'd0, tx_valid, tx_data}, 32'h150);
    tick(); chk("pong_n3", {23'd0, tx_valid, tx_data}, 32'h14F);
    tick(); chk("pong_n4", {23'd0, tx_valid, tx_data}, 32'h14E);
    tick(); chk("pong_n5", {23'd0, tx_valid, tx_data}, 32'h147);
    tick();
    chk("pong_n6_done", {31'd0, done}, 1);
    chk("pong_n6_valid", {31'd0, tx_valid}, 0);
    chk("pong_n6_busy", {31'd0, busy}, 1);
    tick();
    chk("pong_n7_busy", {31'd0, busy}, 0);
    chk("pong_n7_done", {31'd0, done}, 0);
    tick();

    // Zero-length string: no bytes, done at N+2
    zero_len = 1'b1;
    id = 2'd1; start = 1'b1;
    tick(); start = 1'b0;
    chk("zl_n1_valid", {31'd0, tx_valid}, 0);
    chk("zl_n1_done", {31'd0, done}, 0);
    tick();
    chk("zl_n2_done", {31'd0, done}, 1);
    chk("zl_n2_valid", {31'd0, tx_valid}, 0);
    tick();
    chk("zl_n3_busy", {31'd0, busy}, 0);
    chk("zl_n3_valid", {31'd0, tx_valid}, 0);
    zero_len = 1'b0;
    tick();
`else
    expect_str("PONG");
    run(2'd3, 0, -1);
    cmp_bytes("crlf_pong");
    zero_len = 1'b1;
    expect_str("");
    run(2'd1, 0, -1);
    cmp_bytes("crlf_zl");
    zero_len = 1'b0;
`endif

    // Stalling receiver
    expect_str("\n$>");
    run(2'd1, 1, -1);
    cmp_bytes("stall");

    // Start during the second SEND cycle is ignored
    expect_str("PONG");
    run(2'd3, 0, 2);
    cmp_bytes("busy_start");

    // Start coinciding with done is dropped (done lands one cycle after the last byte)
    expect_str("PONG");
    run(2'd3, 0, exp.size() + 1);
    cmp_bytes("done_start");

    // Reset mid-string after the second byte
    id = 2'd0; start = 1'b1;
    tick(); start = 1'b0;
    tick(); chk("abort_b0", {23'd0, tx_valid, tx_data}, 32'h165);
    tick(); chk("abort_b1", {23'd0, tx_valid, tx_data}, 32'h172);
    tick(); rst = 1'b1;
    tick(); rst = 1'b0;
    chk("abort_valid", {31'd0, tx_valid}, 0);
    chk("abort_busy", {31'd0, busy}, 0);
    chk("abort_romid", {30'd0, rom_id}, 0);
    tick();
    chk("abort_valid2", {31'd0, tx_valid}, 0);
    expect_str("PONG");
    run(2'd3, 0, -1);
    cmp_bytes("after_abort");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
